branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating counters; the producer of the fetch-redirect signals `target_taken` and `br_mispred` that IF control consumes.
- The fetch side performs a same-cycle lookup on the fetch PC to produce the predicted target.
- The execute side compares each resolved branch against the prediction carried down the pipe. It raises a mispredict with the recovery PC and trains the table.
- Also keeps branch and mispredict performance counters for CSR readout.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, minimum 2.
IDX_W, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
stall  input  1  pipeline stall; execute slot is held this cycle
fetch_pc  input  32  PC being fetched
target_taken  output  1  predicted taken for fetch_pc
target_pc  output  32  predicted target for fetch_pc
ex_valid  input  1  execute slot holds a valid instruction
ex_is_branch  input  1  instruction is a conditional branch or JAL/JALR
ex_pc  input  32  PC of execute instruction
ex_taken  input  1  resolved direction
ex_target  input  32  resolved target (ALU result)
ex_pred_taken  input  1  target_taken captured at fetch, piped to execute
ex_pred_target  input  32  target_pc captured at fetch, piped to execute
br_mispred  output  1  execute-stage misprediction
recovery_pc  output  32  correct next PC when br_mispred=1
branch_count  output  32  resolved branches retired
mispred_count  output  32  mispredictions

Behaviour:
- Entry fields: valid, tag = pc[31:IDX_W+2], target[31:2], ctr[1:0].
- Lookup (combinational, zero latency):
  - idx = fetch_pc[IDX_W+1:2].
  - hit = valid && tag match.
  - target_taken = hit && ctr[1] && !rst.
  - target_pc = {target, 2'b00} on hit, else fetch_pc+4.
- Lookup sees table state before any same-cycle write. A write at the same index is visible from the next cycle.
- Mispredict (combinational), with e = ex_valid && !rst:
  - Branch case: e && ex_is_branch && (ex_taken != ex_pred_taken || (ex_taken && ex_pred_target != ex_target)).
  - Non-branch case: e && !ex_is_branch && ex_pred_taken (stale entry).
  - br_mispred is the OR of the two cases.
- recovery_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc+4. Arithmetic is modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
- br_mispred is driven regardless of stall. IF control latches the redirect during stall.
- Update enable: u = ex_valid && !stall && !rst. There is exactly one update per instruction, even if the execute slot is held for multiple cycles.
- Training, for ex_is_branch at index of ex_pc:
  - Hit and taken: ctr saturating increment (3 stays 3); target <= ex_target[31:2].
  - Hit and not taken: ctr saturating decrement (0 stays 0); target unchanged.
  - Miss and taken: allocate (replace any occupant): valid=1, tag, target, ctr=2'b10.
  - Miss and not taken: no change.
- Training, for !ex_is_branch && ex_pred_taken: clear valid at that index if the tag matches.
- Counters:
  - On u && ex_is_branch: branch_count += 1.
  - On u && br_mispred: mispred_count += 1.
  - Both wrap 0xFFFFFFFF -> 0.
- Reset:
  - All valid bits cleared and ctr set to 2'b01 on the cycle rst is sampled; targets and tags are don't-care.
  - Counters = 0; target_taken=0 and br_mispred=0 while rst is high.
  - Reset mid-operation discards any pending update that cycle.
- Simultaneous fetch lookup and execute update on the same index: the lookup returns old data, and the update commits at the clock edge.

Test Plan:
- After reset, fetch_pc=0x1000_0000 -> target_taken=0, target_pc=0x1000_0004. Counters read 0.
- Branch at 0x1000_0010 resolves taken to 0x1000_0040 with ex_pred_taken=0 -> br_mispred=1, recovery_pc=0x1000_0040. Next cycle, fetch of 0x1000_0010 -> target_taken=1, target_pc=0x1000_0040. mispred_count=1.
- Same branch resolves not-taken twice with correct prediction flags -> first: br_mispred=1, recovery_pc=0x1000_0014, ctr 10->01. Second: predicted 0, no mispred, ctr 01->00. Then fetch -> target_taken=0.
- Mispredicted branch held with stall=1 for 3 cycles, then released -> br_mispred=1 for all 4 cycles. branch_count and mispred_count each increment by exactly 1.
- Aliasing: 0x1000_0010 and 0x1000_0050 (ENTRIES=16) -> allocating the second evicts the first. Fetch of 0x1000_0010 then gives target_taken=0.
- Non-branch at a PC with ex_pred_taken=1 -> br_mispred=1, recovery_pc=ex_pc+4, and the entry is invalidated. Also check ex_pc=0xFFFF_FFFC -> recovery_pc=0x0000_0000.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch side: zero-latency lookup on fetch_pc.
// Execute side: misprediction detection, recovery PC, table training and
// branch / mispredict performance counters.
module branch_predictor #(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] fetch_pc,
  output logic        target_taken,
  output logic [31:0] target_pc,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        br_mispred,
  output logic [31:0] recovery_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispred_count
);

  localparam int TAG_W = 30 - IDX_W;

  // Table storage; tags and targets carry no reset value.
  logic               valid_q [ENTRIES];
  logic [1:0]         ctr_q   [ENTRIES];
  logic [TAG_W-1:0]   tag_q   [ENTRIES];
  logic [29:0]        tgt_q   [ENTRIES];

  logic [31:0]        branch_count_q, branch_count_d;
  logic [31:0]        mispred_count_q, mispred_count_d;

  // Fetch-side lookup signals
  logic [IDX_W-1:0]   f_idx;
  logic [TAG_W-1:0]   f_tag;
  logic               f_hit;

  // Execute-side signals
  logic [IDX_W-1:0]   ex_idx;
  logic [TAG_W-1:0]   ex_tag;
  logic               ex_tag_match;
  logic               ex_hit;
  logic               ex_en;
  logic               upd_en;
  logic               mis_branch;
  logic               mis_stale;

  // Next-state values for the single entry addressed by ex_pc
  logic               entry_we;
  logic               valid_d;
  logic [1:0]         ctr_d;
  logic [TAG_W-1:0]   tag_d;
  logic [29:0]        tgt_d;

  assign f_idx  = fetch_pc[IDX_W+1:2];
  assign f_tag  = fetch_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];

  // Fetch lookup reads the registered table, so a same-cycle write at the
  // same index only becomes visible after the clock edge.
  always_comb begin
    f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    target_taken = f_hit && ctr_q[f_idx][1] && !rst;
    target_pc    = f_hit ? {tgt_q[f_idx], 2'b00} : (fetch_pc + 32'd4);
  end

  // Misprediction detection and recovery PC; independent of stall so IF
  // control sees the redirect while the execute slot is held.
  always_comb begin
    ex_en        = ex_valid && !rst;
    upd_en       = ex_valid && !stall && !rst;
    ex_tag_match = (tag_q[ex_idx] == ex_tag);
    ex_hit       = valid_q[ex_idx] && ex_tag_match;
    mis_branch   = ex_en && ex_is_branch &&
                   ((ex_taken != ex_pred_taken) ||
                    (ex_taken && (ex_pred_target != ex_target)));
    mis_stale    = ex_en && !ex_is_branch && ex_pred_taken;
    br_mispred   = mis_branch || mis_stale;
    recovery_pc  = (ex_is_branch && ex_taken) ? ex_target : (ex_pc + 32'd4);
  end

  // Training: compute the new contents of the entry at ex_idx.
  always_comb begin
    entry_we = 1'b0;
    valid_d  = valid_q[ex_idx];
    ctr_d    = ctr_q[ex_idx];
    tag_d    = tag_q[ex_idx];
    tgt_d    = tgt_q[ex_idx];
    if (upd_en) begin
      if (ex_is_branch) begin
        if (ex_hit) begin
          entry_we = 1'b1;
          if (ex_taken) begin
            ctr_d = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
            tgt_d = ex_target[31:2];
          end else begin
            ctr_d = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
          end
        end else if (ex_taken) begin
          entry_we = 1'b1;
          valid_d  = 1'b1;
          tag_d    = ex_tag;
          tgt_d    = ex_target[31:2];
          ctr_d    = 2'b10;
        end
      end else if (ex_pred_taken && ex_tag_match) begin
        // A non-branch predicted taken means the entry is stale.
        entry_we = 1'b1;
        valid_d  = 1'b0;
      end
    end
  end

  // Counter next-state; both wrap naturally at 2^32.
  always_comb begin
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (upd_en && ex_is_branch) branch_count_d  = branch_count_q + 32'd1;
    if (upd_en && br_mispred)   mispred_count_d = mispred_count_q + 32'd1;
  end

  // Valid bits and counters: reset clears, otherwise commit the trained entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (entry_we) begin
      valid_q[ex_idx] <= valid_d;
      ctr_q[ex_idx]   <= ctr_d;
    end
  end

  // Tag and target storage; entry_we is already gated off during reset.
  always_ff @(posedge clk) begin
    if (entry_we) begin
      tag_q[ex_idx] <= tag_d;
      tgt_q[ex_idx] <= tgt_d;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q  <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign branch_count  = branch_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (ENTRIES=16).
module tb_branch_predictor;

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] fetch_pc;
  logic        target_taken;
  logic [31:0] target_pc;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        br_mispred;
  logic [31:0] recovery_pc;
  logic [31:0] branch_count;
  logic [31:0] mispred_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .fetch_pc       (fetch_pc),
    .target_taken   (target_taken),
    .target_pc      (target_pc),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .br_mispred     (br_mispred),
    .recovery_pc    (recovery_pc),
    .branch_count   (branch_count),
    .mispred_count  (mispred_count)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_is_branch   = br;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic ex_idle();
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] pc,
                           input logic exp_tk, input logic [31:0] exp_pc);
    fetch_pc = pc;
    #1;
    chk({tag, "_tk"}, {31'd0, target_taken}, {31'd0, exp_tk});
    chk({tag, "_pc"}, target_pc, exp_pc);
  endtask

  task automatic chk_counts(input string tag, input logic [31:0] exp_b, input logic [31:0] exp_m);
    chk({tag, "_bcnt"}, branch_count, exp_b);
    chk({tag, "_mcnt"}, mispred_count, exp_m);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    fetch_pc = 32'h1000_0000;
    ex_idle();
    step();
    step();
    chk("rst_tk", {31'd0, target_taken}, 32'd0);
    rst = 1'b0;

    // Reset state
    chk_fetch("post_rst", 32'h1000_0000, 1'b0, 32'h1000_0004);
    chk_counts("post_rst", 32'd0, 32'd0);

    // Allocate 0x10000010 -> 0x10000040, predicted not-taken: mispredict.
    drive_ex(1'b1, 1'b1, 32'h1000_0010, 1'b1, 32'h1000_0040, 1'b0, 32'h1000_0014);
    chk_fetch("same_cyc_old", 32'h1000_0010, 1'b0, 32'h1000_0014);
    chk("alloc_mis", {31'd0, br_mispred}, 32'd1);
    chk("alloc_rec", recovery_pc, 32'h1000_0040);
    step();
    ex_idle();
    chk_fetch("alloc_hit", 32'h1000_0010, 1'b1, 32'h1000_0040);
    chk_counts("alloc", 32'd1, 32'd1);

    // Not taken, predicted taken: mispredict, ctr 10 -> 01.
    drive_ex(1'b1, 1'b1, 32'h1000_0010, 1'b0, 32'h1000_0040, 1'b1, 32'h1000_0040);
    #1;
    chk("nt1_mis", {31'd0, br_mispred}, 32'd1);
    chk("nt1_rec", recovery_pc, 32'h1000_0014);
    step();
    // Not taken, predicted not taken: correct, ctr 01 -> 00.
    drive_ex(1'b1, 1'b1, 32'h1000_0010, 1'b0, 32'h1000_0040, 1'b0, 32'h1000_0014);
    #1;
    chk("nt2_mis", {31'd0, br_mispred}, 32'd0);
    step();
    ex_idle();
    chk_fetch("nt_fetch", 32'h1000_0010, 1'b0, 32'h1000_0040);
    chk_counts("nt", 32'd3, 32'd2);

    // Mispredict held by stall for 3 cycles: one update only.
    drive_ex(1'b1, 1'b1, 32'h1000_0020, 1'b1, 32'h1000_0100, 1'b0, 32'h1000_0024);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_mis", {31'd0, br_mispred}, 32'd1);
      step();
      chk_counts("stall", 32'd3, 32'd2);
      chk_fetch("stall_noupd", 32'h1000_0020, 1'b0, 32'h1000_0024);
    end
    stall = 1'b0;
    #1;
    chk("rel_mis", {31'd0, br_mispred}, 32'd1);
    step();
    ex_idle();
    chk_counts("rel", 32'd4, 32'd3);
    chk_fetch("rel_fetch", 32'h1000_0020, 1'b1, 32'h1000_0100);

    // Bring 0x10000010 back to predict taken (00 -> 01 -> 10).
    drive_ex(1'b1, 1'b1, 32'h1000_0010, 1'b1, 32'h1000_0040, 1'b0, 32'h1000_0014);
    step();
    step();
    ex_idle();
    chk_fetch("retrain", 32'h1000_0010, 1'b1, 32'h1000_0040);
    // Aliasing branch 0x10000050 evicts it.
    drive_ex(1'b1, 1'b1, 32'h1000_0050, 1'b1, 32'h1000_0080, 1'b0, 32'h1000_0054);
    step();
    ex_idle();
    chk_fetch("alias_new", 32'h1000_0050, 1'b1, 32'h1000_0080);
    chk_fetch("alias_old", 32'h1000_0010, 1'b0, 32'h1000_0014);
    chk_counts("alias", 32'd7, 32'd6);

    // Stale entry: non-branch at 0x10000050 predicted taken.
    drive_ex(1'b1, 1'b0, 32'h1000_0050, 1'b0, 32'h0, 1'b1, 32'h1000_0080);
    #1;
    chk("stale_mis", {31'd0, br_mispred}, 32'd1);
    chk("stale_rec", recovery_pc, 32'h1000_0054);
    step();
    ex_idle();
    chk_fetch("stale_inv", 32'h1000_0050, 1'b0, 32'h1000_0054);
    chk_counts("stale", 32'd7, 32'd7);

    // Recovery PC wraps at the top of the address space.
    drive_ex(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1000_0000);
    #1;
    chk("wrap_mis", {31'd0, br_mispred}, 32'd1);
    chk("wrap_rec", recovery_pc, 32'h0000_0000);
    step();
    ex_idle();
    #1;
    chk("idle_mis", {31'd0, br_mispred}, 32'd0);
    chk_counts("wrap", 32'd7, 32'd8);

    // Correct taken prediction (ctr 10 -> 11), then wrong target.
    drive_ex(1'b1, 1'b1, 32'h1000_0020, 1'b1, 32'h1000_0100, 1'b1, 32'h1000_0100);
    #1;
    chk("ok_mis", {31'd0, br_mispred}, 32'd0);
    chk("ok_rec", recovery_pc, 32'h1000_0100);
    step();
    drive_ex(1'b1, 1'b1, 32'h1000_0020, 1'b1, 32'h1000_0200, 1'b1, 32'h1000_0100);
    #1;
    chk("tgt_mis", {31'd0, br_mispred}, 32'd1);
    chk("tgt_rec", recovery_pc, 32'h1000_0200);
    step();
    ex_idle();
    chk_fetch("tgt_fetch", 32'h1000_0020, 1'b1, 32'h1000_0200);
    chk_counts("tgt", 32'd9, 32'd9);

    // Reset in the middle of a pending update discards it.
    drive_ex(1'b1, 1'b1, 32'h1000_0030, 1'b1, 32'h1000_0300, 1'b0, 32'h1000_0034);
    rst = 1'b1;
    #1;
    chk("rst_mis", {31'd0, br_mispred}, 32'd0);
    fetch_pc = 32'h1000_0020;
    #1;
    chk("rst_tk2", {31'd0, target_taken}, 32'd0);
    step();
    rst = 1'b0;
    ex_idle();
    chk_counts("rst2", 32'd0, 32'd0);
    chk_fetch("rst2_old", 32'h1000_0020, 1'b0, 32'h1000_0024);
    chk_fetch("rst2_drop", 32'h1000_0030, 1'b0, 32'h1000_0034);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
